ay_psg: RTL

AY-3-8912-compatible PSG core: the chip-side responder for the BDIR/BC1 bus that the CPU-side AY controller drives. It decodes latch-address, write and read strobes into a 16-entry register file, and runs three tone generators, one noise generator, one envelope generator and the mixer. It outputs three 4-bit channel levels for the DAC/mixing stage. It sits in the clk28 domain and is enabled at the AY clock rate by a clock-enable pulse.

---
 rtl/psg_pkg.sv | 44 ++++
 rtl/psg_tone.sv | 33 +++
 rtl/ay_psg.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// Shared definitions for the AY-3-8912-compatible PSG: register map,
// writable-bit masks, envelope shape bit positions and bus strobe decode.
package psg_pkg;

  localparam logic [3:0] R_TONE_A_L  = 4'd0;
  localparam logic [3:0] R_TONE_A_H  = 4'd1;
  localparam logic [3:0] R_TONE_B_L  = 4'd2;
  localparam logic [3:0] R_TONE_B_H  = 4'd3;
  localparam logic [3:0] R_TONE_C_L  = 4'd4;
  localparam logic [3:0] R_TONE_C_H  = 4'd5;
  localparam logic [3:0] R_NOISE     = 4'd6;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_AMP_A     = 4'd8;
  localparam logic [3:0] R_AMP_B     = 4'd9;
  localparam logic [3:0] R_AMP_C     = 4'd10;
  localparam logic [3:0] R_ENV_L     = 4'd11;
  localparam logic [3:0] R_ENV_H     = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_PORT_A    = 4'd14;
  localparam logic [3:0] R_PORT_B    = 4'd15;

  // Bit positions inside R13
  localparam int ENV_HOLD = 0;
  localparam int ENV_ALT  = 1;
  localparam int ENV_ATT  = 2;
  localparam int ENV_CONT = 3;

  // Encoded as {bdir, bc1}
  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_LATCH = 2'b11
  } bus_op_t;

  function automatic logic [7:0] reg_mask(input logic [3:0] idx);
    case (idx)
      R_TONE_A_H, R_TONE_B_H, R_TONE_C_H, R_ENV_SHAPE: reg_mask = 8'h0F;
      R_NOISE, R_AMP_A, R_AMP_B, R_AMP_C:              reg_mask = 8'h1F;
      default:                                         reg_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/psg_tone.sv
// One square-wave tone generator: 12-bit period counter that toggles the
// output each time it reaches the programmed period.
module psg_tone (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [11:0] period,
  output logic        tone
);

  logic [11:0] cnt_reg;
  logic [11:0] limit;
  logic        tone_reg;

  // A zero period behaves like a period of one.
  assign limit = (period == 12'd0) ? 12'd0 : period - 12'd1;
  assign tone  = tone_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      tone_reg <= 1'b0;
    end else if (tick) begin
      if (cnt_reg >= limit) begin
        cnt_reg  <= '0;
        tone_reg <= ~tone_reg;
      end else begin
        cnt_reg <= cnt_reg + 12'd1;
      end
    end
  end

endmodule

// File: rtl/ay_psg.sv
// AY-3-8912-compatible PSG core: BDIR/BC1 bus responder, register file,
// three tone generators, noise, envelope and mixer, all advanced on ce.
module ay_psg
  import psg_pkg::*;
(
  input  logic       clk28,
  input  logic       rst,
  input  logic       ce,
  input  logic       bdir,
  input  logic       bc1,
  input  logic [7:0] di,
  // read data bus; "do" itself is a reserved word
  output logic [7:0] dout,
  output logic       do_oe,
  output logic [3:0] ch_a,
  output logic [3:0] ch_b,
  output logic [3:0] ch_c
);

  logic [7:0] regs [16];
  logic [3:0] addr_reg;
  logic       addr_ok_reg;
  logic [7:0] dout_reg;
  logic       do_oe_reg;
  bus_op_t    bus_op;
  logic       reg_wr;
  logic       env_wr;

  assign bus_op = bus_op_t'({bdir, bc1});
  assign reg_wr = (bus_op == BUS_WRITE) && addr_ok_reg;
  assign env_wr = reg_wr && (addr_reg == R_ENV_SHAPE);
  assign dout   = dout_reg;
  assign do_oe  = do_oe_reg;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_wr) begin
      regs[addr_reg] <= di & reg_mask(addr_reg);
    end
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      addr_reg    <= '0;
      addr_ok_reg <= 1'b1;
      dout_reg    <= '0;
      do_oe_reg   <= 1'b0;
    end else begin
      do_oe_reg <= 1'b0;
      case (bus_op)
        BUS_LATCH: begin
          if (di[7:4] == 4'd0) begin
            addr_reg    <= di[3:0];
            addr_ok_reg <= 1'b1;
          end else begin
            addr_ok_reg <= 1'b0;
          end
        end
        BUS_READ: begin
          dout_reg  <= addr_ok_reg ? (regs[addr_reg] & reg_mask(addr_reg)) : 8'hFF;
          do_oe_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Prescaler: tone every 8 ce, envelope every 16 ce, noise every 2nd tone tick.
  logic [3:0] presc_reg;
  logic       noise_div_reg;
  logic       tone_tick;
  logic       env_tick;
  logic       noise_tick;

  assign tone_tick  = ce && (presc_reg[2:0] == 3'd7);
  assign env_tick   = ce && (presc_reg == 4'hF);
  assign noise_tick = tone_tick && noise_div_reg;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      presc_reg     <= '0;
      noise_div_reg <= 1'b0;
    end else begin
      if (ce) presc_reg <= presc_reg + 4'd1;
      if (tone_tick) noise_div_reg <= ~noise_div_reg;
    end
  end

  logic [4:0]  noise_cnt_reg;
  logic [4:0]  noise_lim;
  logic [16:0] lfsr_reg;
  logic        noise;

  assign noise_lim = (regs[R_NOISE][4:0] == 5'd0) ? 5'd0 : regs[R_NOISE][4:0] - 5'd1;
  assign noise     = lfsr_reg[0];

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      noise_cnt_reg <= '0;
      lfsr_reg      <= 17'd1;
    end else if (noise_tick) begin
      if (noise_cnt_reg >= noise_lim) begin
        noise_cnt_reg <= '0;
        lfsr_reg      <= {lfsr_reg[0] ^ lfsr_reg[3], lfsr_reg[16:1]};
      end else begin
        noise_cnt_reg <= noise_cnt_reg + 5'd1;
      end
    end
  end

  // Envelope. env_run keeps it parked after reset until R13 is written.
  logic [15:0] env_period;
  logic [15:0] env_lim;
  logic [15:0] env_cnt_reg;
  logic [4:0]  env_step_reg;
  logic        env_held_reg;
  logic        env_inv_reg;
  logic        env_run_reg;
  logic        env_cont;
  logic        env_att;
  logic        env_alt;
  logic        env_hold;
  logic [3:0]  env_level;

  assign env_period = {regs[R_ENV_H], regs[R_ENV_L]};
  assign env_lim    = (env_period == 16'd0) ? 16'd0 : env_period - 16'd1;
  assign env_cont   = regs[R_ENV_SHAPE][ENV_CONT];
  assign env_att    = regs[R_ENV_SHAPE][ENV_ATT];
  assign env_alt    = regs[R_ENV_SHAPE][ENV_ALT];
  assign env_hold   = regs[R_ENV_SHAPE][ENV_HOLD];

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      env_cnt_reg  <= '0;
      env_step_reg <= '0;
      env_held_reg <= 1'b0;
      env_inv_reg  <= 1'b0;
      env_run_reg  <= 1'b0;
    end else if (env_wr) begin
      env_cnt_reg  <= '0;
      env_step_reg <= '0;
      env_held_reg <= 1'b0;
      env_inv_reg  <= 1'b0;
      env_run_reg  <= 1'b1;
    end else if (env_run_reg && !env_held_reg && env_tick) begin
      if (env_cnt_reg >= env_lim) begin
        env_cnt_reg  <= '0;
        env_step_reg <= (env_step_reg == 5'd31) ? 5'd16 : env_step_reg + 5'd1;
        // Crossing a 16-step boundary decides hold versus direction change.
        if (env_step_reg[3:0] == 4'hF) begin
          if (!env_cont || env_hold) env_held_reg <= 1'b1;
          else if (env_alt)          env_inv_reg  <= ~env_inv_reg;
        end
      end else begin
        env_cnt_reg <= env_cnt_reg + 16'd1;
      end
    end
  end

  always_comb begin
    env_level = 4'h0;
    if (env_held_reg)
      env_level = (env_cont && (env_att ^ env_alt)) ? 4'hF : 4'h0;
    else if (env_att ^ env_inv_reg)
      env_level = env_step_reg[3:0];
    else
      env_level = 4'hF - env_step_reg[3:0];
  end

  logic [2:0]  tone;
  logic [11:0] ch_bus;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic       gate;
    logic [3:0] level;
    logic [3:0] ch_reg;

    psg_tone u_tone (
      .clk    (clk28),
      .rst    (rst),
      .tick   (tone_tick),
      .period ({regs[2*gi+1][3:0], regs[2*gi]}),
      .tone   (tone[gi])
    );

    assign gate  = (tone[gi] | regs[R_MIXER][gi]) & (noise | regs[R_MIXER][gi+3]);
    assign level = regs[8+gi][4] ? env_level : regs[8+gi][3:0];

    always_ff @(posedge clk28 or posedge rst) begin
      if (rst) ch_reg <= '0;
      else     ch_reg <= gate ? level : 4'h0;
    end

    assign ch_bus[4*gi +: 4] = ch_reg;
  end

  assign ch_a = ch_bus[3:0];
  assign ch_b = ch_bus[7:4];
  assign ch_c = ch_bus[11:8];

endmodule
